// File: rtl/atm_pkg.sv
// Shared encodings and widths for the ATM session controller.
package atm_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned PIN_DIGITS = 4;
  localparam int unsigned PIN_W      = DIGIT_W * PIN_DIGITS;
  localparam int unsigned BAL_W_DEF  = 8;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_PIN     = 3'd1,
    ST_CHECK   = 3'd2,
    ST_READY   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  // True when the keypad digit is a legal decimal digit.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(9);
  endfunction

endpackage

// File: rtl/atm_timeout_ctr.sv
// Idle-cycle counter; expired_o flags the last idle cycle before timeout.
module atm_timeout_ctr #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded from the register only; the controller gates it with its state.
  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session FSM: card/PIN handling, try lockout, balance updates and idle timeout.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned BAL_W     = BAL_W_DEF,
  parameter logic [15:0] PIN_CODE  = 16'h1234,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               card_in,
  input  logic [DIGIT_W-1:0] pin_digit,
  input  logic               pin_valid,
  input  logic               dep_pulse,
  input  logic               wdr_pulse,
  input  logic               done_btn,
  output logic [BAL_W-1:0]   balance,
  output logic               session_active,
  output logic               locked,
  output logic               err_insuf,
  output logic               err_sat,
  output logic [STATE_W-1:0] state_out
);

  localparam int unsigned TRY_W  = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam int unsigned DCNT_W = (PIN_DIGITS > 1) ? $clog2(PIN_DIGITS) : 1;
  localparam logic [DCNT_W-1:0] LAST_DIGIT = DCNT_W'(PIN_DIGITS - 1);
  localparam logic [BAL_W-1:0]  BAL_MAX    = {BAL_W{1'b1}};
  localparam logic [TRY_W-1:0]  TRY_LIMIT  = TRY_W'(MAX_TRIES);

  state_e             state_q, state_d;
  logic [BAL_W-1:0]   bal_q, bal_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic [PIN_W-1:0]   shreg_q, shreg_d;
  logic               err_insuf_q, err_insuf_d;
  logic               err_sat_q, err_sat_d;

  logic activity;
  logic to_en;
  logic to_clr;
  logic to_expired;

  assign activity = pin_valid | dep_pulse | wdr_pulse | done_btn;
  assign to_en    = (state_q == ST_PIN) || (state_q == ST_READY);

  always_comb begin
    state_d     = state_q;
    bal_d       = bal_q;
    tries_d     = tries_q;
    dcnt_d      = dcnt_q;
    shreg_d     = shreg_q;
    err_insuf_d = 1'b0;
    err_sat_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (card_in) state_d = ST_PIN;
      end

      ST_PIN: begin
        if (!card_in) begin
          state_d = ST_IDLE;
        end else if (pin_valid && is_bcd(pin_digit)) begin
          shreg_d = {shreg_q[PIN_W-DIGIT_W-1:0], pin_digit};
          if (dcnt_q == LAST_DIGIT) begin
            state_d = ST_CHECK;
          end else begin
            dcnt_d = dcnt_q + DCNT_W'(1);
          end
        end else if (!activity && to_expired) begin
          state_d = ST_IDLE;
        end
      end

      // Card removal skips the comparison, so it never costs a try.
      ST_CHECK: begin
        if (!card_in) begin
          state_d = ST_IDLE;
        end else if (shreg_q == PIN_W'(PIN_CODE)) begin
          tries_d = '0;
          state_d = ST_READY;
        end else begin
          tries_d = tries_q + TRY_W'(1);
          state_d = (tries_d == TRY_LIMIT) ? ST_LOCKOUT : ST_PIN;
        end
      end

      ST_READY: begin
        if (!card_in) begin
          state_d = ST_IDLE;
        end else begin
          if (dep_pulse && !wdr_pulse) begin
            if (bal_q == BAL_MAX) err_sat_d = 1'b1;
            else                  bal_d     = bal_q + BAL_W'(1);
          end else if (wdr_pulse && !dep_pulse) begin
            if (bal_q == '0) err_insuf_d = 1'b1;
            else             bal_d       = bal_q - BAL_W'(1);
          end
          if (done_btn) begin
            state_d = ST_IDLE;
          end else if (!activity && to_expired) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_LOCKOUT: begin
        state_d = ST_LOCKOUT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every entry into PIN starts a fresh digit sequence.
    if ((state_d == ST_PIN) && (state_q != ST_PIN)) begin
      dcnt_d  = '0;
      shreg_d = '0;
    end
  end

  assign to_clr = !to_en || activity || (state_d != state_q);

  atm_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (to_clr),
    .en_i      (to_en),
    .expired_o (to_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bal_q       <= '0;
      tries_q     <= '0;
      dcnt_q      <= '0;
      shreg_q     <= '0;
      err_insuf_q <= 1'b0;
      err_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bal_q       <= bal_d;
      tries_q     <= tries_d;
      dcnt_q      <= dcnt_d;
      shreg_q     <= shreg_d;
      err_insuf_q <= err_insuf_d;
      err_sat_q   <= err_sat_d;
    end
  end

  assign balance        = bal_q;
  assign session_active = (state_q == ST_READY);
  assign locked         = (state_q == ST_LOCKOUT);
  assign err_insuf      = err_insuf_q;
  assign err_sat        = err_sat_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl with hand-computed expectations.
module tb_atm_session_ctrl;

  logic       clk;
  logic       reset;
  logic       card_in;
  logic [3:0] pin_digit;
  logic       pin_valid;
  logic       dep_pulse;
  logic       wdr_pulse;
  logic       done_btn;
  logic [7:0] balance;
  logic       session_active;
  logic       locked;
  logic       err_insuf;
  logic       err_sat;
  logic [2:0] state_out;

  int ncmp = 0;
  int nerr = 0;

  atm_session_ctrl #(
    .BAL_W     (8),
    .PIN_CODE  (16'h1234),
    .MAX_TRIES (3),
    .TIMEOUT   (20)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .card_in        (card_in),
    .pin_digit      (pin_digit),
    .pin_valid      (pin_valid),
    .dep_pulse      (dep_pulse),
    .wdr_pulse      (wdr_pulse),
    .done_btn       (done_btn),
    .balance        (balance),
    .session_active (session_active),
    .locked         (locked),
    .err_insuf      (err_insuf),
    .err_sat        (err_sat),
    .state_out      (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic digit(input logic [3:0] d);
    pin_digit = d;
    pin_valid = 1'b1;
    step();
    pin_valid = 1'b0;
  endtask

  task automatic enter_pin(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 0; i < 4; i++) digit(c[15-4*i -: 4]);
  endtask

  task automatic dep();
    dep_pulse = 1'b1;
    step();
    dep_pulse = 1'b0;
  endtask

  task automatic wdr();
    wdr_pulse = 1'b1;
    step();
    wdr_pulse = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},  32'(state_out),      32'd0);
    chk({tag, "_bal"},    32'(balance),        32'd0);
    chk({tag, "_active"}, 32'(session_active), 32'd0);
    chk({tag, "_locked"}, 32'(locked),         32'd0);
    chk({tag, "_einsuf"}, 32'(err_insuf),      32'd0);
    chk({tag, "_esat"},   32'(err_sat),        32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; card_in = 1'b0; pin_digit = 4'd0; pin_valid = 1'b0;
    dep_pulse = 1'b0; wdr_pulse = 1'b0; done_btn = 1'b0;
    step();
    step();
    chk_reset_outputs("por");
    reset = 1'b0;

    // Requests outside READY do nothing.
    dep();
    chk("dep_idle_bal", 32'(balance), 32'd0);

    // Session 1: correct PIN with an ignored non-BCD digit.
    card_in = 1'b1;
    step();
    chk("idle_to_pin", 32'(state_out), 32'd1);
    digit(4'd1);
    digit(4'hA);
    digit(4'd2);
    digit(4'd3);
    chk("pin_after_3", 32'(state_out), 32'd1);
    digit(4'd4);
    chk("check_cycle", 32'(state_out), 32'd2);
    step();
    chk("ready", 32'(state_out), 32'd3);
    chk("active", 32'(session_active), 32'd1);

    wdr();
    chk("wdr0_bal", 32'(balance), 32'd0);
    chk("wdr0_einsuf", 32'(err_insuf), 32'd1);
    chk("wdr0_esat", 32'(err_sat), 32'd0);
    step();
    chk("einsuf_1cyc", 32'(err_insuf), 32'd0);

    repeat (3) dep();
    chk("dep3_bal", 32'(balance), 32'd3);
    chk("dep3_active", 32'(session_active), 32'd1);
    repeat (4) dep();
    chk("dep7_bal", 32'(balance), 32'd7);

    dep_pulse = 1'b1; wdr_pulse = 1'b1;
    step();
    dep_pulse = 1'b0; wdr_pulse = 1'b0;
    chk("both_bal", 32'(balance), 32'd7);
    chk("both_einsuf", 32'(err_insuf), 32'd0);
    chk("both_esat", 32'(err_sat), 32'd0);
    wdr();
    chk("wdr_bal", 32'(balance), 32'd6);
    dep();
    chk("dep_bal", 32'(balance), 32'd7);

    done_btn = 1'b1;
    step();
    done_btn = 1'b0;
    chk("done_state", 32'(state_out), 32'd0);
    chk("done_bal", 32'(balance), 32'd7);
    chk("done_active", 32'(session_active), 32'd0);
    card_in = 1'b0;
    step();

    // Session 2: card pulled mid-PIN.
    card_in = 1'b1;
    step();
    digit(4'd1);
    digit(4'd2);
    card_in = 1'b0;
    step();
    chk("pull_pin", 32'(state_out), 32'd0);

    // Session 3: saturate then time out.
    card_in = 1'b1;
    step();
    enter_pin(16'h1234);
    step();
    chk("s3_ready", 32'(state_out), 32'd3);
    chk("s3_bal", 32'(balance), 32'd7);
    dep_pulse = 1'b1;
    repeat (248) step();
    dep_pulse = 1'b0;
    chk("max_bal", 32'(balance), 32'd255);
    chk("max_esat", 32'(err_sat), 32'd0);
    dep();
    chk("sat_bal", 32'(balance), 32'd255);
    chk("sat_esat", 32'(err_sat), 32'd1);
    step();
    chk("esat_1cyc", 32'(err_sat), 32'd0);
    repeat (18) step();
    chk("idle19_state", 32'(state_out), 32'd3);
    step();
    chk("timeout_state", 32'(state_out), 32'd0);
    chk("timeout_bal", 32'(balance), 32'd255);
    card_in = 1'b0;
    step();

    // Tries persist across sessions and lock on the third miss.
    card_in = 1'b1;
    step();
    enter_pin(16'h9999);
    chk("bad1_check", 32'(state_out), 32'd2);
    step();
    chk("bad1_pin", 32'(state_out), 32'd1);
    enter_pin(16'h9999);
    step();
    chk("bad2_pin", 32'(state_out), 32'd1);
    card_in = 1'b0;
    step();
    chk("bad2_pull", 32'(state_out), 32'd0);
    card_in = 1'b1;
    step();
    enter_pin(16'h9999);
    step();
    chk("lock_state", 32'(state_out), 32'd4);
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_active", 32'(session_active), 32'd0);
    card_in = 1'b0;
    repeat (3) step();
    chk("lock_pull", 32'(state_out), 32'd4);
    card_in = 1'b1;
    enter_pin(16'h1234);
    repeat (3) step();
    dep();
    chk("lock_abs", 32'(state_out), 32'd4);
    chk("lock_bal", 32'(balance), 32'd255);

    reset = 1'b1;
    step();
    reset = 1'b0;
    card_in = 1'b0;
    chk("unlock_state", 32'(state_out), 32'd0);
    chk("unlock_locked", 32'(locked), 32'd0);
    chk("unlock_bal", 32'(balance), 32'd0);
    step();

    // A good PIN clears earlier misses.
    card_in = 1'b1;
    step();
    enter_pin(16'h9999);
    step();
    enter_pin(16'h1234);
    step();
    chk("clr_ready", 32'(state_out), 32'd3);
    done_btn = 1'b1;
    step();
    done_btn = 1'b0;
    step();
    enter_pin(16'h9999);
    step();
    enter_pin(16'h9999);
    step();
    chk("clr_tries", 32'(state_out), 32'd1);
    enter_pin(16'h1234);
    step();
    chk("s4_ready", 32'(state_out), 32'd3);
    repeat (12) dep();
    chk("bal12", 32'(balance), 32'd12);

    // Reset in READY overrides a simultaneous deposit.
    reset = 1'b1;
    dep_pulse = 1'b1;
    step();
    chk_reset_outputs("rst_ready");
    reset = 1'b0;
    dep_pulse = 1'b0;
    card_in = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
